// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch stage feeding the CPU controller.
// Optional speculative next-word prefetch is enabled by defining FETCH_PREFETCH_EN.
module fetch_pc_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int unsigned WAIT_LIMIT   = 8,
  parameter logic [15:0] NOP_WORD     = 16'hF000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        IRWrite,
  input  logic        PCIncrement,
  input  logic [7:0]  PCImmediate,
  input  logic        PCWrite,
  input  logic [15:0] PCTarget,
  input  logic [15:0] MemData,
  input  logic        MemReady,
  output logic        MemReq,
  output logic [15:0] MemAddr,
  output logic [15:0] PC,
  output logic [15:0] INS,
  output logic        InsValid,
  output logic        FetchBusy,
  output logic        FetchErr
);

  localparam int unsigned AW = 16;
  localparam int unsigned IW = 8;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          pend_valid;
  logic          pend_write;
  logic [AW-1:0] pend_target;
  logic [IW-1:0] pend_imm;
  logic          upd_req;
  logic          wait_expired;
  logic [AW-1:0] pc_next;

`ifdef FETCH_PREFETCH_EN
  logic          spec_busy;
  logic          spec_kill;
  logic          ir_pend;
  logic          pf_valid;
  logic [AW-1:0] pf_addr;
  logic [AW-1:0] pf_data;
  logic          inv;
  assign inv = PCWrite | (PCIncrement & (PCImmediate != IW'(1)));
`endif

  assign upd_req      = PCWrite | PCIncrement;
  assign wait_expired = (cnt == CW'(WAIT_LIMIT - 1));

  function automatic logic [AW-1:0] pc_apply(input logic [AW-1:0] base, input logic wr,
                                             input logic [AW-1:0] tgt, input logic [IW-1:0] imm);
    return wr ? tgt : base + {{(AW-IW){imm[IW-1]}}, imm};
  endfunction

  // PC after this edge: immediate when idle, deferred (pending or newest) on return to idle
  always_comb begin
    pc_next = PC;
    case (state)
      S_IDLE: if (upd_req) pc_next = pc_apply(PC, PCWrite, PCTarget, PCImmediate);
      S_DONE: begin
        if (upd_req)         pc_next = pc_apply(PC, PCWrite, PCTarget, PCImmediate);
        else if (pend_valid) pc_next = pc_apply(PC, pend_write, pend_target, pend_imm);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      PC          <= RESET_VECTOR;
      INS         <= NOP_WORD;
      MemReq      <= 1'b0;
      MemAddr     <= '0;
      InsValid    <= 1'b0;
      FetchBusy   <= 1'b0;
      FetchErr    <= 1'b0;
      pend_valid  <= 1'b0;
      pend_write  <= 1'b0;
      pend_target <= '0;
      pend_imm    <= '0;
`ifdef FETCH_PREFETCH_EN
      spec_busy   <= 1'b0;
      spec_kill   <= 1'b0;
      ir_pend     <= 1'b0;
      pf_valid    <= 1'b0;
      pf_addr     <= '0;
      pf_data     <= '0;
`endif
    end else begin
      PC       <= pc_next;
      InsValid <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      if (inv) pf_valid <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
`ifdef FETCH_PREFETCH_EN
          if (spec_busy) begin
            // Background fetch of the likely next word; a demand IRWrite waits for it
            if (IRWrite) ir_pend <= 1'b1;
            if (inv) spec_kill <= 1'b1;
            cnt <= cnt + CW'(1);
            if (MemReady || wait_expired) begin
              MemReq    <= 1'b0;
              spec_busy <= 1'b0;
              if (MemReady && !spec_kill && !inv) begin
                pf_valid <= 1'b1;
                pf_addr  <= MemAddr;
                pf_data  <= MemData;
              end
            end
          end else if (IRWrite || ir_pend) begin
            ir_pend  <= 1'b0;
            pf_valid <= 1'b0;
            if (pf_valid && pf_addr == PC) begin
              INS       <= pf_data;
              InsValid  <= 1'b1;
              FetchBusy <= 1'b1;
              state     <= S_DONE;
            end else begin
              MemAddr   <= PC;
              MemReq    <= 1'b1;
              cnt       <= '0;
              FetchBusy <= 1'b1;
              state     <= S_REQ;
            end
          end
`else
          if (IRWrite) begin
            MemAddr   <= PC;
            MemReq    <= 1'b1;
            cnt       <= '0;
            FetchBusy <= 1'b1;
            state     <= S_REQ;
          end
`endif
        end
        S_REQ: begin
          if (upd_req) begin
            pend_valid  <= 1'b1;
            pend_write  <= PCWrite;
            pend_target <= PCTarget;
            pend_imm    <= PCImmediate;
          end
          cnt <= cnt + CW'(1);
          if (MemReady) begin
            INS      <= MemData;
            MemReq   <= 1'b0;
            InsValid <= 1'b1;
            state    <= S_DONE;
          end else if (wait_expired) begin
            INS      <= NOP_WORD;
            FetchErr <= 1'b1;
            MemReq   <= 1'b0;
            InsValid <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          FetchBusy  <= 1'b0;
          pend_valid <= 1'b0;
`ifdef FETCH_PREFETCH_EN
          spec_busy  <= 1'b1;
          spec_kill  <= 1'b0;
          pf_valid   <= 1'b0;
          MemReq     <= 1'b1;
          MemAddr    <= pc_next + AW'(1);
          cnt        <= '0;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed cases plus randomized fetch/branch traffic
// compared against a transaction-level PC/INS model.
module tb_fetch_pc_unit;

  localparam int unsigned WAIT_LIMIT = 8;
  localparam logic [15:0] NOP = 16'hF000;
  localparam logic [15:0] RV  = 16'h0000;

  logic        Clock = 1'b0;
  logic        Reset, IRWrite, PCIncrement, PCWrite, MemReady;
  logic [7:0]  PCImmediate;
  logic [15:0] PCTarget, MemData;
  logic        MemReq, InsValid, FetchBusy, FetchErr;
  logic [15:0] MemAddr, PC, INS;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mpc, mins;
  logic        merr;

  fetch_pc_unit #(.RESET_VECTOR(RV), .WAIT_LIMIT(WAIT_LIMIT), .NOP_WORD(NOP)) dut (
    .Clock(Clock), .Reset(Reset), .IRWrite(IRWrite), .PCIncrement(PCIncrement),
    .PCImmediate(PCImmediate), .PCWrite(PCWrite), .PCTarget(PCTarget),
    .MemData(MemData), .MemReady(MemReady), .MemReq(MemReq), .MemAddr(MemAddr),
    .PC(PC), .INS(INS), .InsValid(InsValid), .FetchBusy(FetchBusy), .FetchErr(FetchErr)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_inputs();
    IRWrite = 1'b0; PCIncrement = 1'b0; PCWrite = 1'b0; MemReady = 1'b0;
    PCImmediate = 8'h00; PCTarget = 16'h0000; MemData = 16'h0000;
  endtask

  // Reference PC arithmetic: signed displacement, wrap modulo 2^16
  function automatic logic [15:0] apply(input bit w, input logic [7:0] imm,
                                        input logic [15:0] tgt, input logic [15:0] pc);
    int disp;
    if (w) return tgt;
    disp = (imm >= 8'h80) ? int'(imm) - 256 : int'(imm);
    return 16'((int'(pc) + disp + 65536) % 65536);
  endfunction

  task automatic do_reset();
    Reset = 1'b1; clear_inputs();
    step(); step();
    Reset = 1'b0;
    mpc = RV; mins = NOP; merr = 1'b0;
  endtask

  task automatic upd_idle(input bit w, input bit inc, input logic [7:0] imm, input logic [15:0] tgt);
    PCWrite = w; PCIncrement = inc; PCImmediate = imm; PCTarget = tgt;
    MemReady = 1'b1; MemData = 16'($urandom);
    step(); clear_inputs();
    if (w || inc) mpc = apply(w, imm, tgt, mpc);
    chk("idle_pc", PC, mpc);
    chk("idle_ins", INS, mins);
    chk("idle_memreq", 16'(MemReq), 16'd0);
  endtask

  // mode 0: clean fetch, 1: scripted pending updates, 2: random side traffic
  task automatic do_fetch(input int delay, input logic [15:0] data, input int mode);
    logic [15:0] addr, tgt;
    logic [7:0]  imm;
    bit          w, inc, pv, pw, nw;
    logic [7:0]  pimm;
    logic [15:0] ptgt;
    int          last_k;
    last_k = (delay <= int'(WAIT_LIMIT)) ? delay : int'(WAIT_LIMIT);
    addr = mpc;
    pv = 1'b0; pw = 1'b0; pimm = 8'h00; ptgt = 16'h0000;
    IRWrite = 1'b1;
    w = 1'b0; inc = 1'b0; imm = 8'($urandom); tgt = 16'($urandom);
    if (mode == 2 && $urandom_range(0, 2) == 0) begin
      w = 1'($urandom); inc = 1'($urandom);
      PCWrite = w; PCIncrement = inc; PCImmediate = imm; PCTarget = tgt;
    end
    step(); clear_inputs();
    if (w || inc) mpc = apply(w, imm, tgt, mpc);
    chk("req_memreq", 16'(MemReq), 16'd1);
    chk("req_addr", MemAddr, addr);
    chk("req_busy", 16'(FetchBusy), 16'd1);
    chk("req_pc", PC, mpc);
    for (int k = 1; k <= last_k; k++) begin
      w = 1'b0; inc = 1'b0; imm = 8'($urandom); tgt = 16'($urandom);
      if (mode == 1 && k == 1) begin inc = 1'b1; imm = 8'h01; end
      if (mode == 1 && k == 2) begin w = 1'b1; tgt = 16'h0040; end
      if (mode == 2 && $urandom_range(0, 2) == 0) begin w = 1'($urandom); inc = 1'($urandom); end
      if (mode == 2) IRWrite = 1'($urandom);
      PCWrite = w; PCIncrement = inc; PCImmediate = imm; PCTarget = tgt;
      if (w || inc) begin pv = 1'b1; pw = w; pimm = imm; ptgt = tgt; end
      MemReady = (k == delay);
      MemData  = (k == delay) ? data : 16'($urandom);
      step(); clear_inputs();
      if (k < last_k) begin
        chk("wait_memreq", 16'(MemReq), 16'd1);
        chk("wait_addr", MemAddr, addr);
        chk("wait_pc", PC, mpc);
      end
    end
    if (delay > int'(WAIT_LIMIT)) begin mins = NOP; merr = 1'b1; end
    else mins = data;
    chk("done_ins", INS, mins);
    chk("done_valid", 16'(InsValid), 16'd1);
    chk("done_memreq", 16'(MemReq), 16'd0);
    chk("done_busy", 16'(FetchBusy), 16'd1);
    chk("done_pc", PC, mpc);
    chk("done_err", 16'(FetchErr), 16'(merr));
    nw = 1'b0; w = 1'b0; imm = 8'($urandom); tgt = 16'($urandom);
    if (mode == 2) begin
      IRWrite = 1'($urandom);
      MemReady = 1'($urandom); MemData = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        nw = 1'b1; w = 1'($urandom);
        PCWrite = w; PCIncrement = ~w; PCImmediate = imm; PCTarget = tgt;
      end
    end
    step(); clear_inputs();
    if (nw) mpc = apply(w, imm, tgt, mpc);
    else if (pv) mpc = apply(pw, pimm, ptgt, mpc);
    chk("idle_ret_pc", PC, mpc);
    chk("idle_ret_valid", 16'(InsValid), 16'd0);
    chk("idle_ret_busy", 16'(FetchBusy), 16'd0);
    chk("idle_ret_memreq", 16'(MemReq), 16'd0);
    chk("idle_ret_ins", INS, mins);
    chk("idle_ret_err", 16'(FetchErr), 16'(merr));
  endtask

  initial begin
    clear_inputs();
    do_reset();
    chk("rst_pc", PC, 16'h0000);
    chk("rst_ins", INS, 16'hF000);
    chk("rst_memreq", 16'(MemReq), 16'd0);
    chk("rst_memaddr", MemAddr, 16'h0000);
    chk("rst_err", 16'(FetchErr), 16'd0);
    chk("rst_valid", 16'(InsValid), 16'd0);
    chk("rst_busy", 16'(FetchBusy), 16'd0);

    do_fetch(2, 16'h5A13, 0);
    chk("basic_ins", INS, 16'h5A13);

    upd_idle(1'b1, 1'b0, 8'h00, 16'h0010);
    upd_idle(1'b0, 1'b1, 8'hFC, 16'h0000);
    chk("branch_back", PC, 16'h000C);
    upd_idle(1'b1, 1'b0, 8'h00, 16'hFFFF);
    upd_idle(1'b0, 1'b1, 8'h01, 16'h0000);
    chk("wrap_up", PC, 16'h0000);
    upd_idle(1'b0, 1'b1, 8'hFF, 16'h0000);
    chk("wrap_down", PC, 16'hFFFF);
    upd_idle(1'b1, 1'b1, 8'h05, 16'h0200);
    chk("write_wins", PC, 16'h0200);

    do_fetch(8, 16'h1234, 0);
    chk("last_cycle_ok_err", 16'(FetchErr), 16'd0);
    do_fetch(WAIT_LIMIT + 5, 16'hBEEF, 0);
    chk("timeout_ins", INS, 16'hF000);
    chk("timeout_err", 16'(FetchErr), 16'd1);
    do_fetch(1, 16'h0F0F, 0);
    chk("err_sticky", 16'(FetchErr), 16'd1);

    do_fetch(4, 16'h7777, 1);
    chk("pending_pc", PC, 16'h0040);

    do_reset();
    chk("err_cleared", 16'(FetchErr), 16'd0);
    upd_idle(1'b1, 1'b0, 8'h00, 16'h0123);
    IRWrite = 1'b1; step(); clear_inputs();
    step();
    Reset = 1'b1; MemReady = 1'b1; MemData = 16'h1234;
    step(); clear_inputs(); Reset = 1'b0;
    mpc = RV; mins = NOP; merr = 1'b0;
    chk("midrst_ins", INS, 16'hF000);
    chk("midrst_memreq", 16'(MemReq), 16'd0);
    chk("midrst_pc", PC, 16'h0000);
    chk("midrst_busy", 16'(FetchBusy), 16'd0);
    chk("midrst_valid", 16'(InsValid), 16'd0);
    step();
    chk("midrst_idle_req", 16'(MemReq), 16'd0);
    chk("midrst_idle_valid", 16'(InsValid), 16'd0);

    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 2) == 0)
        upd_idle(1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom));
      else
        do_fetch($urandom_range(1, WAIT_LIMIT + 2), 16'($urandom), 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program counter and instruction-fetch stage directly upstream of the CPU controller.
- Holds the PC, runs the memory fetch handshake when the controller strobes IRWrite, and latches the fetched word into the instruction register that drives INS.
- Applies the controller's PC update commands (PCIncrement with signed PCImmediate, PCWrite with absolute target).
- A memory wait-state timeout substitutes a NOP word so the core never hangs.

Parameters:
- RESET_VECTOR, 16'h0000, PC value after reset.
- WAIT_LIMIT, 8, max cycles spent in S_REQ waiting for MemReady before timeout (range 1..255).
- NOP_WORD, 16'hF000, word loaded into INS on timeout (decodes as do-nothing in the controller).

Ports:
- Clock  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- IRWrite  in  1  fetch request strobe from controller.
- PCIncrement  in  1  PC <= PC + sext(PCImmediate).
- PCImmediate  in  8  signed displacement.
- PCWrite  in  1  PC <= PCTarget (takes priority over PCIncrement).
- PCTarget  in  16  absolute jump target.
- MemData  in  16  instruction word from memory.
- MemReady  in  1  MemData valid this cycle.
- MemReq  out  1  fetch request to memory.
- MemAddr  out  16  fetch address, held stable while MemReq=1.
- PC  out  16  current program counter.
- INS  out  16  instruction register.
- InsValid  out  1  one-cycle pulse when INS is newly loaded.
- FetchBusy  out  1  high in S_REQ and S_DONE.
- FetchErr  out  1  sticky, set on timeout.

Behaviour:
- Reset (synchronous, active-high): Clock and Reset are the only clocking/reset ports. Reset takes precedence over all inputs on the same edge, including mid-fetch. Reset values:
  - PC=RESET_VECTOR, INS=NOP_WORD, MemReq=0, MemAddr=0, InsValid=0, FetchErr=0.
  - state=S_IDLE, wait counter=0, pending slot empty.
- FSM states: S_IDLE, S_REQ, S_DONE.
- S_IDLE:
  - IRWrite=1: MemAddr<=PC, MemReq<=1, counter<=0, go to S_REQ.
  - A PC update in the same cycle is applied on the same edge. The fetch uses the pre-update PC.
- S_REQ:
  - MemReq=1; MemAddr stable; counter increments each cycle.
  - MemReady=1: INS<=MemData, MemReq<=0, go to S_DONE. MemReady on the same cycle the counter reaches WAIT_LIMIT counts as success.
  - Counter reaches WAIT_LIMIT without MemReady: INS<=NOP_WORD, FetchErr<=1, MemReq<=0, go to S_DONE.
  - Fetch latency: request edge to INS load is at least 1 cycle and at most WAIT_LIMIT cycles.
- S_DONE:
  - InsValid=1 for exactly this cycle, then return to S_IDLE.
  - IRWrite here is ignored, not queued.
- PC update arithmetic:
  - PCWrite: PC<=PCTarget.
  - Else PCIncrement: PC<=PC+{{8{PCImmediate[7]}},PCImmediate}, modulo 2^16. 16'hFFFF+1 wraps to 0; 16'h0000+8'hFF gives 16'hFFFF.
  - Both asserted: PCWrite wins.
- PC updates while busy (S_REQ/S_DONE):
  - Captured into a one-entry pending slot (kind + operand). A newer request overwrites an older one.
  - Applied on the edge that enters S_IDLE.
  - A new update arriving on that same edge overrides the pending one.
- IRWrite while busy: ignored, no error.
- FetchErr clears only on Reset.
- MemReady outside S_REQ: ignored.

Optional Feature:
- Macro FETCH_PREFETCH_EN.
- Defined:
  - After S_DONE, the unit immediately issues a speculative fetch of PC+1 (post-update PC) and buffers the word in a one-entry prefetch register.
  - The next IRWrite whose PC matches the buffered address loads INS in 1 cycle (S_IDLE->S_DONE), with no memory request.
  - Any PCWrite, or any PCIncrement with an immediate other than 1, invalidates the buffer.
  - A speculative fetch timeout discards the buffer without setting FetchErr.
- Undefined: no prefetch logic; behaviour exactly as above.

Test Plan:
- Reset then idle: after Reset, PC=16'h0000, INS=16'hF000, MemReq=0, FetchErr=0, InsValid=0.
- Basic fetch: IRWrite at PC=0, MemReady after 2 cycles with MemData=16'h5A13 -> MemAddr=0 throughout, INS=16'h5A13, one InsValid pulse, FetchBusy high 3 cycles.
- Branch arithmetic (idle):
  - PC=16'h0010, PCIncrement, PCImmediate=8'hFC -> PC=16'h000C.
  - PC=16'hFFFF, PCImmediate=8'h01 -> PC=16'h0000.
  - PCWrite=1 and PCIncrement=1 with PCTarget=16'h0200 -> PC=16'h0200.
- Timeout: IRWrite, MemReady held 0 for WAIT_LIMIT=8 cycles -> INS=16'hF000, FetchErr=1 and sticky across later good fetches until Reset.
- Pending update: during S_REQ issue PCIncrement imm=1, then PCWrite target=16'h0040 -> PC unchanged until S_IDLE entry, then PC=16'h0040.
- Reset mid-fetch: Reset asserted in S_REQ with MemReady arriving the same edge -> INS stays 16'hF000, MemReq=0, state S_IDLE, PC=RESET_VECTOR.
